instr_rom_fetch_if: RTL and testbench
=====================================

INSTR_ROM_FETCH_IF -- requirements
Module: instr_rom_fetch_if

Interface
- REQ-001: Parameter ADDR_WIDTH, default 32: width of the fetch address (word index).
- REQ-002: Parameter INSTR_WIDTH, default 32: instruction word width.
- REQ-003: Parameter ROM_ADDR_BITS, default 10: per-bank depth is 2**ROM_ADDR_BITS words.
- REQ-004: Parameter NUM_BANKS, default 2, range 1..8: count of contiguous ROM banks.
- REQ-005: Parameter BASE_ADDR, default 0: word address of bank 0 entry 0.
- REQ-006: Parameter FAULT_INSTR, default all-zero: data returned for unmapped fetches.
- REQ-007: CLK  in  1  single clock; all state updates on rising edge.
- REQ-008: RST_N  in  1  reset, asynchronous assert, active-low.
- REQ-009: FLUSH  in  1  discard any held response this cycle.
- REQ-010: REQ_VALID  in  1  fetch request present.
- REQ-011: REQ_ADDR  in  ADDR_WIDTH  fetch word address.
- REQ-012: REQ_READY  out  1  request accepted when REQ_VALID and REQ_READY both high.
- REQ-013: RSP_VALID  out  1  response present.
- REQ-014: RSP_READY  in  1  consumer takes response when RSP_VALID and RSP_READY both high.
- REQ-015: RSP_DATA  out  INSTR_WIDTH  fetched instruction or FAULT_INSTR.
- REQ-016: RSP_FAULT  out  1  response address was unmapped.
- REQ-017: FAULT_COUNT  out  16  saturating count of unmapped fetches accepted.

Function
- REQ-018: Mapped range SHALL be BASE_ADDR .. BASE_ADDR + NUM_BANKS*2**ROM_ADDR_BITS - 1, inclusive, compared at full ADDR_WIDTH without truncation.
- REQ-019: Bank select SHALL be (REQ_ADDR - BASE_ADDR) >> ROM_ADDR_BITS; bank index SHALL be the low ROM_ADDR_BITS of that difference.
- REQ-020: Only the selected bank's read enable SHALL assert, and only on an accepted mapped request.
- REQ-021: State machine SHALL have two states: EMPTY (RSP_VALID=0) and FULL (RSP_VALID=1).
- REQ-022: REQ_READY SHALL equal (state==EMPTY) or RSP_READY, and SHALL be 0 while FLUSH is high.
- REQ-023: Accepted request at edge N SHALL produce RSP_VALID=1 with data after edge N (latency 1 cycle).
- REQ-024: EMPTY->FULL on accept; FULL->EMPTY on RSP_READY without a new accept; FULL->FULL on simultaneous consume and accept (back-to-back, 1 word/cycle).
- REQ-025: While FULL and RSP_READY=0, RSP_DATA, RSP_FAULT SHALL hold stable and no bank SHALL be enabled.
- REQ-026: Unmapped accepted request SHALL yield RSP_DATA=FAULT_INSTR, RSP_FAULT=1, same latency as mapped.
- REQ-027: FAULT_COUNT SHALL increment by 1 per accepted unmapped request and saturate at 16'hFFFF.
- REQ-028: FLUSH=1 SHALL force next state EMPTY regardless of RSP_READY; no request accepted that cycle; FAULT_COUNT unaffected.
- REQ-029: Output data SHALL be selected by a registered bank index captured at accept, never by the live REQ_ADDR.

Reset
- REQ-030: RST_N low SHALL immediately force state EMPTY, RSP_VALID=0, RSP_FAULT=0, RSP_DATA=0, FAULT_COUNT=0, REQ_READY=0 for the reset duration.
- REQ-031: Reset mid-transaction SHALL drop the in-flight response; ROM contents are not reset.
- REQ-032: First request SHALL be accepted on the first rising edge after RST_N deasserts.

Structure
- REQ-033: Shared package SHALL hold the state encoding (EMPTY, FULL) and the FAULT_COUNT width constant.
- REQ-034: One sub-module rom_bank SHALL implement a synchronous-read, enable-gated ROM of 2**ROM_ADDR_BITS x INSTR_WIDTH, instantiated NUM_BANKS times via generate, per-bank init file parameter.

Verification (NUM_BANKS=2, ROM_ADDR_BITS=4, BASE_ADDR=16; mapped 16..47; bank word = 32'hB000_0000 | addr)
- REQ-035: Request addr 16, RSP_READY=1 -> next cycle RSP_VALID=1, RSP_DATA=32'hB000_0010, RSP_FAULT=0.
- REQ-036: Back-to-back addrs 31,32,47 with RSP_READY=1 -> responses 0x1F,0x20,0x2F on consecutive cycles, bank0 then bank1 twice.
- REQ-037: Addr 15 then 48 -> two responses RSP_FAULT=1, RSP_DATA=FAULT_INSTR, FAULT_COUNT=2.
- REQ-038: Addr 20 accepted, RSP_READY=0 for 3 cycles -> RSP_DATA=0x14 stable, REQ_READY=0; RSP_READY=1 -> consumed, REQ_READY=1.
- REQ-039: FULL with FLUSH=1 -> next cycle RSP_VALID=0; RST_N pulsed low mid-stall -> all outputs zero immediately.
- REQ-040: 65536 unmapped fetches -> FAULT_COUNT=16'hFFFF and remains there.

Source files
------------

// File: rtl/instr_rom_fetch_if_pkg.sv
// -----------------------------------------------------------------------------
// instr_rom_fetch_if_pkg
// Shared definitions for the instruction ROM fetch block: the response-holding
// state encoding, the fault counter width and a saturating increment helper.
// -----------------------------------------------------------------------------
package instr_rom_fetch_if_pkg;

    // Response register state: EMPTY holds nothing, FULL holds one response.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } fetch_state_e;

    localparam int FAULT_COUNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [FAULT_COUNT_W-1:0] sat_inc(input logic [FAULT_COUNT_W-1:0] value);
        if (value == {FAULT_COUNT_W{1'b1}}) begin
            return value;
        end else begin
            return value + FAULT_COUNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/instr_rom_fetch_if_if.sv
// -----------------------------------------------------------------------------
// instr_rom_fetch_if_if
// Fetch request/response bus between an instruction fetcher (master) and the
// banked ROM (slave).
//   flush       : master -> slave, drop any held response this cycle
//   req_valid   : master -> slave, request present
//   req_addr    : master -> slave, word address
//   req_ready   : slave -> master, request accepted when valid & ready
//   rsp_valid   : slave -> master, response present
//   rsp_ready   : master -> slave, response taken when valid & ready
//   rsp_data    : slave -> master, instruction word or fault word
//   rsp_fault   : slave -> master, response address was unmapped
//   fault_count : slave -> master, saturating unmapped-fetch count
// -----------------------------------------------------------------------------
interface instr_rom_fetch_if_if
    import instr_rom_fetch_if_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                     flush;
    logic                     req_valid;
    logic [ADDR_WIDTH-1:0]    req_addr;
    logic                     req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [INSTR_WIDTH-1:0]   rsp_data;
    logic                     rsp_fault;
    logic [FAULT_COUNT_W-1:0] fault_count;

    modport master (
        output flush, req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_fault, fault_count
    );

    modport slave (
        input  flush, req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_fault, fault_count
    );
endinterface

// File: rtl/instr_rom_fetch_if_rom_bank.sv
// -----------------------------------------------------------------------------
// rom_bank
// One synchronous-read, enable-gated ROM bank of 2**ROM_ADDR_BITS words.
// The bank image is set per instance by parameters: entry i holds
// INIT_TAG | (INIT_BASE + i), so each bank carries its own contents without
// any load-time file access.
//   clk, rst_n : clock, async active-low reset (clears the read register only)
//   en         : read enable; rdata updates only when high
//   idx        : entry index within the bank
//   rdata      : registered read data
// -----------------------------------------------------------------------------
module rom_bank #(
    parameter int                     INSTR_WIDTH   = 32,
    parameter int                     ROM_ADDR_BITS = 10,
    parameter logic [INSTR_WIDTH-1:0] INIT_TAG      = '0,
    parameter logic [INSTR_WIDTH-1:0] INIT_BASE     = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [ROM_ADDR_BITS-1:0] idx,
    output logic [INSTR_WIDTH-1:0]   rdata
);

    logic [INSTR_WIDTH-1:0] rdata_r;

    // Constant bank image: a pure function of the entry index.
    function automatic logic [INSTR_WIDTH-1:0] rom_word(input logic [ROM_ADDR_BITS-1:0] i);
        return INIT_TAG | (INIT_BASE + INSTR_WIDTH'(i));
    endfunction

    // Synchronous read; the register holds its value while the bank is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else if (en) begin
            rdata_r <= rom_word(idx);
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/instr_rom_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_rom_fetch_if
// Banked instruction ROM behind a valid/ready fetch port with one response
// register (one word per cycle, one cycle latency). Addresses outside the
// mapped window return FAULT_INSTR with rsp_fault set and bump fault_count.
//   clk, rst_n : clock, async active-low reset
//   bus        : instr_rom_fetch_if_if slave modport (request, response, flush,
//                fault count)
// -----------------------------------------------------------------------------
module instr_rom_fetch_if
    import instr_rom_fetch_if_pkg::*;
#(
    parameter int                     ADDR_WIDTH    = 32,
    parameter int                     INSTR_WIDTH   = 32,
    parameter int                     ROM_ADDR_BITS = 10,
    parameter int                     NUM_BANKS     = 2,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR     = '0,
    parameter logic [INSTR_WIDTH-1:0] FAULT_INSTR   = '0,
    parameter logic [INSTR_WIDTH-1:0] ROM_TAG       = 32'hB000_0000
) (
    input logic                  clk,
    input logic                  rst_n,
    instr_rom_fetch_if_if.slave  bus
);

    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    // Extra headroom bits so the window check never wraps or truncates.
    localparam int EXT_W = ADDR_WIDTH + 4;
    localparam logic [EXT_W-1:0] BASE_EXT = EXT_W'(BASE_ADDR);
    localparam logic [EXT_W-1:0] SPAN_EXT = EXT_W'(NUM_BANKS) << ROM_ADDR_BITS;

    fetch_state_e             state_r;
    logic [BANK_BITS-1:0]     bank_r;
    logic                     fault_r;
    logic [FAULT_COUNT_W-1:0] count_r;

    logic [EXT_W-1:0]         addr_ext_s;
    logic [EXT_W-1:0]         offset_s;
    logic                     mapped_s;
    logic [BANK_BITS-1:0]     bank_sel_s;
    logic [ROM_ADDR_BITS-1:0] bank_idx_s;
    logic                     req_ready_s;
    logic                     accept_s;
    logic [NUM_BANKS-1:0]     bank_en_s;
    logic [INSTR_WIDTH-1:0]   bank_rdata_s [NUM_BANKS];
    logic [INSTR_WIDTH-1:0]   rsp_data_s;

    // Address decode: window check, bank select and in-bank index.
    always_comb begin
        addr_ext_s = {4'b0000, bus.req_addr};
        offset_s   = addr_ext_s - BASE_EXT;
        mapped_s   = (addr_ext_s >= BASE_EXT) && (offset_s < SPAN_EXT);
        bank_sel_s = offset_s[ROM_ADDR_BITS +: BANK_BITS];
        bank_idx_s = offset_s[ROM_ADDR_BITS-1:0];
    end

    // Ready while empty or while the held word is being taken; never in
    // reset or during a flush.
    always_comb begin
        req_ready_s = 1'b0;
        if (!rst_n || bus.flush) begin
            req_ready_s = 1'b0;
        end else begin
            req_ready_s = (state_r == ST_EMPTY) || bus.rsp_ready;
        end
        accept_s = bus.req_valid && req_ready_s;
    end

    // One-hot bank enables, only for an accepted in-window request.
    always_comb begin
        bank_en_s = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_en_s[b] = accept_s && mapped_s && (bank_sel_s == BANK_BITS'(b));
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        rom_bank #(
            .INSTR_WIDTH   (INSTR_WIDTH),
            .ROM_ADDR_BITS (ROM_ADDR_BITS),
            .INIT_TAG      (ROM_TAG),
            .INIT_BASE     (INSTR_WIDTH'(BASE_ADDR) + (INSTR_WIDTH'(g) << ROM_ADDR_BITS))
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bank_en_s[g]),
            .idx   (bank_idx_s),
            .rdata (bank_rdata_s[g])
        );
    end

    // Response FSM plus captured bank/fault tag and the fault counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
            bank_r  <= '0;
            fault_r <= 1'b0;
            count_r <= '0;
        end else begin
            if (accept_s) begin
                bank_r  <= bank_sel_s;
                fault_r <= !mapped_s;
                if (!mapped_s) begin
                    count_r <= sat_inc(count_r);
                end
            end
            if (bus.flush) begin
                state_r <= ST_EMPTY;
            end else begin
                case (state_r)
                    ST_EMPTY: state_r <= accept_s ? ST_FULL : ST_EMPTY;
                    ST_FULL: begin
                        if (accept_s) begin
                            state_r <= ST_FULL;
                        end else if (bus.rsp_ready) begin
                            state_r <= ST_EMPTY;
                        end else begin
                            state_r <= ST_FULL;
                        end
                    end
                    default: state_r <= ST_EMPTY;
                endcase
            end
        end
    end

    // Response data comes from the bank captured at accept, not the live address.
    always_comb begin
        rsp_data_s = '0;
        if (state_r != ST_FULL) begin
            rsp_data_s = '0;
        end else if (fault_r) begin
            rsp_data_s = FAULT_INSTR;
        end else begin
            rsp_data_s = bank_rdata_s[bank_r];
        end
    end

    assign bus.req_ready   = req_ready_s;
    assign bus.rsp_valid   = (state_r == ST_FULL);
    assign bus.rsp_fault   = (state_r == ST_FULL) && fault_r;
    assign bus.rsp_data    = rsp_data_s;
    assign bus.fault_count = count_r;

endmodule

// File: tb/tb_instr_rom_fetch_if.sv
// -----------------------------------------------------------------------------
// tb_instr_rom_fetch_if
// Self-checking bench for instr_rom_fetch_if with two 16-word banks at word 16.
// A behavioural model tracks whether a response word is outstanding, what it
// should contain and how many unmapped fetches were taken.
// -----------------------------------------------------------------------------
module tb_instr_rom_fetch_if;

    localparam logic [31:0] FAULT_W = 32'hDEAD_BEEF;
    localparam logic [31:0] TAG_W   = 32'hB000_0000;

    logic clk;
    logic rst_n;

    instr_rom_fetch_if_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    instr_rom_fetch_if #(
        .ADDR_WIDTH    (32),
        .INSTR_WIDTH   (32),
        .ROM_ADDR_BITS (4),
        .NUM_BANKS     (2),
        .BASE_ADDR     (32'd16),
        .FAULT_INSTR   (FAULT_W),
        .ROM_TAG       (TAG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Model state
    bit          m_full;
    logic [31:0] m_data;
    bit          m_fault;
    int          m_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; checks ready before the edge and the
    // response/count after it.
    task automatic tick(input logic fl, input logic v, input logic [31:0] a, input logic rr);
        bit exp_rdy;
        bit acc;
        bus.flush     = fl;
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.rsp_ready = rr;
        #1;
        exp_rdy = !fl && (!m_full || rr);
        check("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_rdy});
        acc = v && exp_rdy;
        @(posedge clk);
        if (fl) begin
            m_full = 1'b0;
        end else if (acc) begin
            m_full  = 1'b1;
            m_fault = !(a >= 32'd16 && a <= 32'd47);
            m_data  = m_fault ? FAULT_W : (TAG_W | a);
            if (m_fault && m_count < 65535) m_count++;
        end else if (rr) begin
            m_full = 1'b0;
        end
        #1;
        check("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, m_full});
        if (m_full) begin
            check("rsp_data", bus.rsp_data, m_data);
            check("rsp_fault", {31'd0, bus.rsp_fault}, {31'd0, m_fault});
        end
        check("fault_count", {16'd0, bus.fault_count}, m_count);
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_data", bus.rsp_data, 32'd0);
        check("rst_fault", {31'd0, bus.rsp_fault}, 32'd0);
        check("rst_count", {16'd0, bus.fault_count}, 32'd0);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m_full = 1'b0; m_data = 32'd0; m_fault = 1'b0; m_count = 0;

        // Reset with a request and a ready consumer present.
        rst_n = 1'b0;
        bus.flush = 1'b0; bus.req_valid = 1'b1; bus.req_addr = 32'd16; bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // First edge after release accepts; single mapped fetch.
        tick(1'b0, 1'b1, 32'd16, 1'b1);
        check("first_word", bus.rsp_data, 32'hB000_0010);
        tick(1'b0, 1'b0, 32'd0, 1'b1);

        // Back-to-back across the bank boundary, then the last mapped word.
        tick(1'b0, 1'b1, 32'd31, 1'b1);
        tick(1'b0, 1'b1, 32'd32, 1'b1);
        tick(1'b0, 1'b1, 32'd47, 1'b1);
        check("last_word", bus.rsp_data, 32'hB000_002F);

        // Just below and just above the window.
        tick(1'b0, 1'b1, 32'd15, 1'b1);
        tick(1'b0, 1'b1, 32'd48, 1'b1);
        check("two_faults", {16'd0, bus.fault_count}, 32'd2);
        // Addresses that would alias into the window if truncated or wrapped.
        tick(1'b0, 1'b1, 32'h8000_0010, 1'b1);
        tick(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        tick(1'b0, 1'b0, 32'd0, 1'b1);

        // Stall: held word stays put while a new request is offered.
        tick(1'b0, 1'b1, 32'd20, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 32'd40, 1'b0);
        check("stall_word", bus.rsp_data, 32'hB000_0014);
        tick(1'b0, 1'b0, 32'd40, 1'b1);
        #1;
        check("ready_after_consume", {31'd0, bus.req_ready}, 32'd1);

        // Flush while holding a word.
        tick(1'b0, 1'b1, 32'd21, 1'b0);
        tick(1'b1, 1'b1, 32'd22, 1'b0);

        // Reset asserted while a word is stalled.
        tick(1'b0, 1'b1, 32'd22, 1'b0);
        tick(1'b0, 1'b0, 32'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        m_full = 1'b0; m_count = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic around the window.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                 32'($urandom_range(0, 63)), $urandom_range(0, 3) != 0);
        end

        // Saturate the fault counter and confirm it stays there.
        for (int i = 0; i < 65540; i++) tick(1'b0, 1'b1, 32'd0, 1'b1);
        check("count_sat", {16'd0, bus.fault_count}, 32'h0000_FFFF);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 32'd100, 1'b1);
        check("count_hold", {16'd0, bus.fault_count}, 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
